serial_xs3_bcd_conv: RTL
========================

// Module: serial_xs3_bcd_conv
// PURPOSE
// - Bit-serial, LSB-first code converter for multi-digit words. Excess-3 -> BCD (subtract 3) or BCD -> Excess-3 (add 3).
// - Parametrised successor to the single-digit serial Excess-3 converter: N-digit words, runtime direction select, bit-enable stall, parallel digit/word capture, invalid-code flag.
// - Sits between a serial digit link and the display/datapath logic.
// PARAMETERS
// - DIGITS  4            BCD digits per word (>=1); word = 4*DIGITS bits
// - CNT_W   $clog2(4*DIGITS)  width of the in-word bit counter (derived, not overridden)
// PORTS
// - Clk        in   1         clock, all state on posedge
// - Rst        in   1         reset, asynchronous, active-high
// - En         in   1         X carries a valid bit this cycle; low = stall, all state held
// - X          in   1         serial input bit, LSB of each digit first, digit 0 first
// - Mode       in   1         0 = Excess-3->BCD, 1 = BCD->Excess-3; sampled at word start only
// - Z          out  1         converted bit (Mealy, combinational from X/state, valid when En)
// - DigitOut   out  4         last completed converted digit (registered)
// - DigitVld   out  1         1-cycle pulse, DigitOut updated
// - WordOut    out  4*DIGITS  last completed converted word, digit 0 in [3:0]
// - WordVld    out  1         1-cycle pulse, WordOut updated
// - Err        out  1         1-cycle pulse with DigitVld when the digit was invalid (SERCONV_ERR_EN only)
// BEHAVIOUR
// - Reset: bit counter=0, carry/borrow=0, held mode=0, DigitOut=0, DigitVld=0, WordOut=0, WordVld=0, Err=0.
// - Z is combinational from X, the bit index and carry/borrow: Z = X ^ K[i] ^ cb, where K = 4'b0011 and i = bit-in-digit.
//   - Mode 0: cb' = borrow = (~X & (K|cb)) | (K & cb).
//   - Mode 1: cb' = carry = maj(X, K, cb).
//   - cb is cleared at bit 0 of every digit; carry/borrow out of bit 3 is dropped. Result is modulo 16.
// - Latency: Z valid in the same cycle as X (sample on negedge). DigitOut/DigitVld register on the posedge that consumes bit 3. WordOut/WordVld register on the posedge that consumes the last bit of the word.
// - Counter: advances only when En=1. Wraps from 4*DIGITS-1 to 0; back-to-back words need no gap.
// - Mode is latched when En=1 at counter==0 and used for the whole word. Mode changes mid-word are ignored. Z at bit 0 of a word uses the live Mode input.
// - En=0: Z is don't-care; counter, cb, nibble shift register, outputs and pulses all hold/deassert. DigitVld, WordVld and Err are never held high more than 1 cycle.
// - Rst mid-word: partial digit/word discarded; next En bit is bit 0 of digit 0.
// - A word-end posedge pulses DigitVld and WordVld together. WordOut includes that final digit.
// CONFIGURATION
// - SERCONV_ERR_EN defined: Err is flagged at digit end.
//   - Mode 0: Err when borrow out of bit 3 (input < 3) or result > 9 (input > 12).
//   - Mode 1: Err when carry out of bit 3 or result > 12 (input > 9).
//   - Conversion output is unaffected; the invalid digit is still reported as its mod-16 value.
// - SERCONV_ERR_EN undefined: Err tied to 0, no error logic present.
// STRUCTURE
// - serconv_pkg holds:
//   - MODE_XS3_TO_BCD = 1'b0, MODE_BCD_TO_XS3 = 1'b1
//   - XS3_OFFSET = 4'd3
//   - BCD_MAX = 4'd9, XS3_MAX = 4'd12
// - Sub-module serconv_bit_cell: 1-bit add/sub of a constant bit with a cb register.
//   - Ports: Clk, Rst, En, Mode, X, K, Clr, Z, CbOut.
// - Top level holds: counter, nibble shift register, word register, error compare.
// TESTING
// - Mode0, X bits 0,0,1,1 (4'b1100) -> Z 1,0,0,1; DigitOut=4'h9 with DigitVld pulse.
// - Mode1, X bits 1,0,1,0 (4'b0101) -> Z 0,0,0,1; DigitOut=4'h8.
// - DIGITS=4, Mode0, digits 4'h3,4'h7,4'hC,4'h5 back-to-back -> WordOut=16'h2940 with WordVld at bit 16; then 10000 random valid digits vs a model.
// - En low 3 cycles between bits 1 and 2 of a digit -> result identical to the unstalled run; no pulses during the stall.
// - Mode0 input 4'b0001 -> Z 0,1,1,1 (4'hE). With SERCONV_ERR_EN: Err pulses with DigitVld. Without it: Err stays 0.
// - Rst asserted after bit 5 of a word -> all outputs 0; next 16 bits form a clean word with correct WordOut.

Source files
------------

// File: rtl/serconv_pkg.sv
// Shared constants and types for the bit-serial Excess-3 <-> BCD converter.
package serconv_pkg;

    localparam logic       MODE_XS3_TO_BCD = 1'b0;
    localparam logic       MODE_BCD_TO_XS3 = 1'b1;
    localparam logic [3:0] XS3_OFFSET      = 4'd3;
    localparam logic [3:0] BCD_MAX         = 4'd9;
    localparam logic [3:0] XS3_MAX         = 4'd12;

    typedef struct packed {
        logic [3:0] digit;
        logic       vld;
        logic       err;
    } digit_rsp_t;

endpackage

// File: rtl/serconv_bit_cell.sv
// One-bit serial add/subtract of a constant bit, with carry/borrow register.
// Clr masks the stored carry/borrow so each digit starts from zero.
module serconv_bit_cell
    import serconv_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Mode,
    input  logic X,
    input  logic K,
    input  logic Clr,
    output logic Z,
    output logic CbOut
);

    logic cb;
    logic cb_in;

    assign cb_in = Clr ? 1'b0 : cb;
    assign Z     = X ^ K ^ cb_in;

    always_comb begin
        CbOut = 1'b0;
        if (Mode == MODE_BCD_TO_XS3)
            CbOut = (X & K) | (X & cb_in) | (K & cb_in);
        else
            CbOut = (~X & (K | cb_in)) | (K & cb_in);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)     cb <= 1'b0;
        else if (En) cb <= CbOut;
    end

endmodule

// File: rtl/serial_xs3_bcd_conv.sv
// Bit-serial LSB-first Excess-3 <-> BCD converter for DIGITS-digit words.
// Define SERCONV_ERR_EN to flag invalid input digits on Err.
module serial_xs3_bcd_conv
    import serconv_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CNT_W  = $clog2(4*DIGITS)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En,
    input  logic                X,
    input  logic                Mode,
    output logic                Z,
    output logic [3:0]          DigitOut,
    output logic                DigitVld,
    output logic [4*DIGITS-1:0] WordOut,
    output logic                WordVld,
    output logic                Err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(4*DIGITS-1);

    logic [CNT_W-1:0]        cnt;
    logic [1:0]              bidx;
    logic                    mode_q, mode_eff;
    logic [2:0]              nib;
    logic [3:0]              digit;
    logic                    digit_end, word_end;
    logic [DIGITS-1:0][3:0]  word_acc, word_nxt;
    digit_rsp_t              rsp;

    assign bidx      = cnt[1:0];
    // Bit 0 of a word runs on the live Mode; the rest of the word uses the latched copy.
    assign mode_eff  = (cnt == '0) ? Mode : mode_q;
    assign digit     = {Z, nib};
    assign digit_end = En && (bidx == 2'd3);
    assign word_end  = En && (cnt == LAST);

`ifdef SERCONV_ERR_EN
    logic cb_out;
`else
    logic cb_out_unused;
`endif

    serconv_bit_cell u_cell (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (En),
        .Mode  (mode_eff),
        .X     (X),
        .K     (XS3_OFFSET[bidx]),
        .Clr   (bidx == 2'd0),
        .Z     (Z),
`ifdef SERCONV_ERR_EN
        .CbOut (cb_out)
`else
        .CbOut (cb_out_unused)
`endif
    );

    always_comb begin
        word_nxt = word_acc;
        for (int d = 0; d < DIGITS; d++)
            if (CNT_W'(d) == (cnt >> 2)) word_nxt[d] = digit;
    end

    always_comb begin
        rsp.digit = digit;
        rsp.vld   = digit_end;
        rsp.err   = 1'b0;
`ifdef SERCONV_ERR_EN
        // Out-of-range digits: underflow/overflow of bit 3, or a result past the code range.
        if (mode_eff == MODE_XS3_TO_BCD)
            rsp.err = digit_end && (cb_out || (digit > BCD_MAX));
        else
            rsp.err = digit_end && (cb_out || (digit > XS3_MAX));
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt      <= '0;
            mode_q   <= MODE_XS3_TO_BCD;
            nib      <= '0;
            word_acc <= '0;
            DigitOut <= '0;
            DigitVld <= 1'b0;
            WordOut  <= '0;
            WordVld  <= 1'b0;
        end else begin
            DigitVld <= rsp.vld;
            WordVld  <= word_end;
            if (En) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                nib <= {Z, nib[2:1]};
                if (cnt == '0) mode_q <= Mode;
            end
            if (digit_end) begin
                DigitOut <= rsp.digit;
                word_acc <= word_nxt;
            end
            if (word_end) WordOut <= word_nxt;
        end
    end

`ifdef SERCONV_ERR_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Err <= 1'b0;
        else     Err <= rsp.err;
    end
`else
    assign Err = 1'b0;
`endif

endmodule
